// File: rtl/wb_ram_responder_pkg.sv
// Shared definitions for the Wishbone RAM responder: FSM encodings, byte-lane
// bit positions and the wait-state counter width helper.
package wb_ram_responder_pkg;

    typedef enum logic [1:0] {
        WBR_IDLE = 2'b00,
        WBR_WAIT = 2'b01,
        WBR_ACK  = 2'b10,
        WBR_ERR  = 2'b11
    } wbr_state_e;

    localparam int WB_SEL_HI = 1;
    localparam int WB_SEL_LO = 0;

    // Counter must hold WAIT_STATES-1 but never collapses to zero width.
    function automatic int cnt_width(input int wait_states);
        int w;
        w = $clog2(wait_states + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/wb_ram_array.sv
// Single-port halfword RAM with two byte-lane write enables and a registered
// read port that only updates on read accesses.
module wb_ram_array
    import wb_ram_responder_pkg::*;
#(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 we,
    input  logic [1:0]           sel,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [15:0]          wdata,
    output logic [15:0]          rdata
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [7:0] mem_hi [DEPTH];
    logic [7:0] mem_lo [DEPTH];

    // Storage is deliberately not reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (en && we && sel[WB_SEL_HI]) begin
            mem_hi[addr] <= wdata[15:8];
        end
        if (en && we && sel[WB_SEL_LO]) begin
            mem_lo[addr] <= wdata[7:0];
        end
    end

    // Read register holds its last value across writes and idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= {mem_hi[addr], mem_lo[addr]};
        end
    end

endmodule

// File: rtl/wb_ram_responder.sv
// Wishbone classic responder serving on-chip RAM with programmable wait
// states; out-of-window accesses terminate with a one-cycle error pulse.
//
// state | meaning
// IDLE  | waiting for cyc & stb
// WAIT  | in-window request, counting down inserted wait states
// ACK   | RAM accessed on entry, ack pulse high for this cycle
// ERR   | out-of-window request, err pulse high for this cycle
module wb_ram_responder
    import wb_ram_responder_pkg::*;
#(
    parameter int          ADDR_BITS   = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic [1:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    localparam int CNT_BITS = cnt_width(WAIT_STATES);

    wbr_state_e          state;
    logic [CNT_BITS-1:0] cnt;
    logic                ack;
    logic                err;
    logic                req;
    logic                in_win;
    logic                access;
    logic                unused_adr0;

    assign req         = wb_cyc_i & wb_stb_i;
    assign in_win      = (wb_adr_i[31:ADDR_BITS+1] == BASE_ADDR[31:ADDR_BITS+1]);
    assign unused_adr0 = wb_adr_i[0];

    // RAM is touched only on the edge that enters ACK; reset suppresses it so
    // a write still waiting in WAIT is dropped.
    always_comb begin
        access = 1'b0;
        if (!rst_i && req) begin
            case (state)
                WBR_IDLE: access = in_win && (WAIT_STATES == 0);
                WBR_WAIT: access = (cnt == '0);
                default:  access = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= WBR_IDLE;
            cnt   <= '0;
            ack   <= 1'b0;
            err   <= 1'b0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            case (state)
                WBR_IDLE: begin
                    if (req) begin
                        if (!in_win) begin
                            state <= WBR_ERR;
                            err   <= 1'b1;
                        end else if (WAIT_STATES == 0) begin
                            state <= WBR_ACK;
                            ack   <= 1'b1;
                        end else begin
                            state <= WBR_WAIT;
                            cnt   <= CNT_BITS'(WAIT_STATES - 1);
                        end
                    end
                end
                WBR_WAIT: begin
                    if (!req) begin
                        state <= WBR_IDLE;
                    end else if (cnt == '0) begin
                        state <= WBR_ACK;
                        ack   <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WBR_ACK:  state <= WBR_IDLE;
                WBR_ERR:  state <= WBR_IDLE;
                default:  state <= WBR_IDLE;
            endcase
        end
    end

    assign wb_ack_o = ack;
    assign wb_err_o = err;

    wb_ram_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk   (clk_i),
        .rst   (rst_i),
        .en    (access),
        .we    (wb_we_i),
        .sel   (wb_sel_i),
        .addr  (wb_adr_i[ADDR_BITS:1]),
        .wdata (wb_dat_i),
        .rdata (wb_dat_o)
    );

endmodule

// File: tb/tb_wb_ram_responder.sv
// Directed bench for wb_ram_responder: one instance with no wait states and
// one with three, both using a 4 KB window at 0x1000.
module tb_wb_ram_responder;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic [31:0] adr   [2];
    logic [15:0] dat_w [2];
    logic [15:0] dat_r [2];
    logic [1:0]  sel   [2];
    logic        we    [2];
    logic        cyc   [2];
    logic        stb   [2];
    logic        ack   [2];
    logic        err   [2];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_ram_responder #(
        .ADDR_BITS   (11),
        .BASE_ADDR   (32'h0000_1000),
        .WAIT_STATES (0)
    ) dut0 (
        .clk_i    (clk),
        .rst_i    (rst[0]),
        .wb_adr_i (adr[0]),
        .wb_dat_i (dat_w[0]),
        .wb_dat_o (dat_r[0]),
        .wb_sel_i (sel[0]),
        .wb_we_i  (we[0]),
        .wb_cyc_i (cyc[0]),
        .wb_stb_i (stb[0]),
        .wb_ack_o (ack[0]),
        .wb_err_o (err[0])
    );

    wb_ram_responder #(
        .ADDR_BITS   (11),
        .BASE_ADDR   (32'h0000_1000),
        .WAIT_STATES (3)
    ) dut3 (
        .clk_i    (clk),
        .rst_i    (rst[1]),
        .wb_adr_i (adr[1]),
        .wb_dat_i (dat_w[1]),
        .wb_dat_o (dat_r[1]),
        .wb_sel_i (sel[1]),
        .wb_we_i  (we[1]),
        .wb_cyc_i (cyc[1]),
        .wb_stb_i (stb[1]),
        .wb_ack_o (ack[1]),
        .wb_err_o (err[1])
    );

    typedef struct {
        int          d;
        bit          wr;
        logic [31:0] a;
        logic [15:0] wd;
        logic [1:0]  s;
        bit          exp_ack;
        bit          exp_err;
        bit          chk_dat;
        logic [15:0] exp_dat;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int d, input bit wr, input logic [31:0] a,
                                input logic [15:0] wd, input logic [1:0] s,
                                input bit ea, input bit ee, input bit cd,
                                input logic [15:0] ed, input int el);
        vec_t v;
        v.d = d; v.wr = wr; v.a = a; v.wd = wd; v.s = s;
        v.exp_ack = ea; v.exp_err = ee; v.chk_dat = cd; v.exp_dat = ed; v.exp_lat = el;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Starts on a negedge, returns on a negedge with the bus idle for one
    // cycle so the next request is seen from IDLE.
    task automatic bus_xfer(input int d, input bit wr, input logic [31:0] a,
                            input logic [15:0] wd, input logic [1:0] s,
                            output bit ga, output bit ge, output logic [15:0] gd,
                            output int lat, output bit tail);
        adr[d] = a; dat_w[d] = wd; sel[d] = s; we[d] = wr;
        cyc[d] = 1'b1; stb[d] = 1'b1;
        ga = 1'b0; ge = 1'b0; gd = '0; lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (ack[d] || err[d]) begin
                ga = ack[d]; ge = err[d]; gd = dat_r[d]; lat = c;
                break;
            end
        end
        cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
        @(negedge clk);
        tail = ack[d] | err[d];
    endtask

    logic [31:0] b2b_adr [4];
    logic [15:0] b2b_dat [4];

    initial begin
        bit          ga, ge, tail;
        logic [15:0] gd;
        int          lat;
        int          k;
        int          last;

        b2b_adr[0] = 32'h0000_1010; b2b_dat[0] = 16'hA0A0;
        b2b_adr[1] = 32'h0000_1012; b2b_dat[1] = 16'hB1B1;
        b2b_adr[2] = 32'h0000_1014; b2b_dat[2] = 16'hC2C2;
        b2b_adr[3] = 32'h0000_1016; b2b_dat[3] = 16'hD3D3;

        //  d  wr  addr           wdata     sel    ack err cd  exp_dat   lat
        add(0, 1, 32'h0000_1002, 16'hBEEF, 2'b11, 1, 0, 0, 16'h0000, 1);
        add(0, 0, 32'h0000_1003, 16'h0000, 2'b11, 1, 0, 1, 16'hBEEF, 1);
        add(0, 1, 32'h0000_1002, 16'h1234, 2'b10, 1, 0, 0, 16'h0000, 1);
        add(0, 0, 32'h0000_1002, 16'h0000, 2'b00, 1, 0, 1, 16'h12EF, 1);
        add(0, 1, 32'h0000_1002, 16'h0056, 2'b01, 1, 0, 0, 16'h0000, 1);
        add(0, 0, 32'h0000_1002, 16'h0000, 2'b11, 1, 0, 1, 16'h1256, 1);
        add(0, 1, 32'h0000_1002, 16'hFFFF, 2'b00, 1, 0, 0, 16'h0000, 1);
        add(0, 0, 32'h0000_1002, 16'h0000, 2'b11, 1, 0, 1, 16'h1256, 1);
        add(0, 1, 32'h0000_1000, 16'hCAFE, 2'b11, 1, 0, 0, 16'h0000, 1);
        add(0, 0, 32'h0000_1000, 16'h0000, 2'b11, 1, 0, 1, 16'hCAFE, 1);
        add(0, 1, 32'h0000_0FFE, 16'h5555, 2'b11, 0, 1, 1, 16'hCAFE, 1);
        add(0, 1, 32'h0000_3000, 16'h5555, 2'b11, 0, 1, 1, 16'hCAFE, 1);
        add(0, 0, 32'h0000_1000, 16'h0000, 2'b11, 1, 0, 1, 16'hCAFE, 1);
        add(0, 1, 32'h0000_1010, 16'hA0A0, 2'b11, 1, 0, 0, 16'h0000, 1);
        add(0, 1, 32'h0000_1012, 16'hB1B1, 2'b11, 1, 0, 0, 16'h0000, 1);
        add(0, 1, 32'h0000_1014, 16'hC2C2, 2'b11, 1, 0, 0, 16'h0000, 1);
        add(0, 1, 32'h0000_1016, 16'hD3D3, 2'b11, 1, 0, 0, 16'h0000, 1);
        add(1, 1, 32'h0000_1004, 16'h1111, 2'b11, 1, 0, 0, 16'h0000, 4);
        add(1, 0, 32'h0000_1004, 16'h0000, 2'b11, 1, 0, 1, 16'h1111, 4);
        add(1, 1, 32'h0000_0FFE, 16'h5555, 2'b11, 0, 1, 1, 16'h1111, 1);
        add(1, 1, 32'h0000_3000, 16'h5555, 2'b11, 0, 1, 1, 16'h1111, 1);
        add(1, 0, 32'h0000_1004, 16'h0000, 2'b11, 1, 0, 1, 16'h1111, 4);

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; adr[d] = '0; dat_w[d] = '0; sel[d] = '0;
            we[d] = 1'b0; cyc[d] = 1'b0; stb[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset ack d%0d", d), 32'(ack[d]), 32'd0);
            chk($sformatf("reset err d%0d", d), 32'(err[d]), 32'd0);
            chk($sformatf("reset dat d%0d", d), 32'(dat_r[d]), 32'h0);
            rst[d] = 1'b0;
        end
        @(negedge clk);

        foreach (vecs[i]) begin
            bus_xfer(vecs[i].d, vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].s,
                     ga, ge, gd, lat, tail);
            chk($sformatf("v%0d ack", i), 32'(ga), 32'(vecs[i].exp_ack));
            chk($sformatf("v%0d err", i), 32'(ge), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d pulse width", i), 32'(tail), 32'd0);
            if (vecs[i].chk_dat) chk($sformatf("v%0d data", i), 32'(gd), 32'(vecs[i].exp_dat));
        end

        // Back-to-back reads with stb held high on the zero-wait instance.
        k = 0; last = 0;
        adr[0] = b2b_adr[0]; we[0] = 1'b0; sel[0] = 2'b11;
        cyc[0] = 1'b1; stb[0] = 1'b1;
        for (int c = 1; c <= 30 && k < 4; c++) begin
            @(negedge clk);
            if (ack[0]) begin
                chk($sformatf("b2b%0d data", k), 32'(dat_r[0]), 32'(b2b_dat[k]));
                chk($sformatf("b2b%0d spacing", k), 32'(c - last), (k == 0) ? 32'd1 : 32'd2);
                last = c;
                k++;
                if (k < 4) adr[0] = b2b_adr[k];
            end
        end
        cyc[0] = 1'b0; stb[0] = 1'b0;
        chk("b2b ack count", 32'(k), 32'd4);
        @(negedge clk);

        // Abort: stb drops while the write is still waiting.
        adr[1] = 32'h0000_1004; dat_w[1] = 16'hAAAA; sel[1] = 2'b11;
        we[1] = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("abort early term", 32'(ack[1] | err[1]), 32'd0);
        end
        stb[1] = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("abort no ack", 32'(ack[1] | err[1]), 32'd0);
        end
        cyc[1] = 1'b0; we[1] = 1'b0;
        bus_xfer(1, 1'b0, 32'h0000_1004, 16'h0000, 2'b11, ga, ge, gd, lat, tail);
        chk("abort readback", 32'(gd), 32'h1111);
        chk("abort readback lat", 32'(lat), 32'd4);

        // Reset while waiting: outputs return to reset values, write dropped.
        adr[1] = 32'h0000_1004; dat_w[1] = 16'hAAAA; sel[1] = 2'b11;
        we[1] = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
        repeat (2) @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        chk("rst-wait ack", 32'(ack[1]), 32'd0);
        chk("rst-wait err", 32'(err[1]), 32'd0);
        chk("rst-wait dat", 32'(dat_r[1]), 32'h0);
        rst[1] = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst-wait quiet", 32'(ack[1] | err[1]), 32'd0);
        end
        bus_xfer(1, 1'b0, 32'h0000_1004, 16'h0000, 2'b11, ga, ge, gd, lat, tail);
        chk("rst-wait readback", 32'(gd), 32'h1111);
        chk("rst-wait readback lat", 32'(lat), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
